// File: rtl/sseg_pkg.sv
// Shared constants, settle-FSM state type and pattern helpers for the
// seven-segment scan decoder. All patterns are active-low, bit 0 = segment a.
package sseg_pkg;

   localparam logic [6:0] UPPER = 7'h1C;  // a,b,f,g lit: upper square
   localparam logic [6:0] LOWER = 7'h23;  // c,d,e,g lit: lower square
   localparam logic [6:0] BLANK = 7'h7F;  // nothing lit

   typedef enum logic {
      ST_SCAN = 1'b0,
      ST_HOLD = 1'b1
   } settle_state_t;

   // Returns {legal, pos}. UPPER on digit d is position d, LOWER on digit d
   // is position 7-d, anything else is not a square.
   function automatic logic [3:0] pattern_to_pos(input logic [1:0] digit,
                                                 input logic [6:0] pattern);
      logic [3:0] res;
      res = 4'h0;
      if (pattern == UPPER)
         res = {1'b1, 1'b0, digit};
      else if (pattern == LOWER)
         res = {1'b1, 3'd7 - {1'b0, digit}};
      return res;
   endfunction

   // Exactly one anode driven low.
   function automatic logic an_legal(input logic [3:0] an);
      logic ok;
      case (an)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
         default:                            ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Digit number of the single low anode; only meaningful when an_legal().
   function automatic logic [1:0] an_index(input logic [3:0] an);
      logic [1:0] idx;
      case (an)
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/sseg_digit_capture.sv
// Samples the anode/segment bus once, then requires SETTLE consecutive
// identical samples on a single-anode value before capturing that digit.
// cap_valid is a one-cycle strobe with no back-pressure: cap_idx and
// cap_pattern are meaningful only in the cycle cap_valid is high.
module sseg_digit_capture
   import sseg_pkg::*;
#(
   parameter int unsigned SETTLE = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    an,
   input  logic [6:0]    sseg,
   output logic          cap_valid,
   output logic [1:0]    cap_idx,
   output logic [6:0]    cap_pattern,
   output settle_state_t state_dbg
);

   localparam logic [7:0] SETTLE_C = 8'(SETTLE);

   logic [3:0]    an_q, an_p;
   logic [6:0]    sseg_q, sseg_p;
   settle_state_t state, state_n;
   logic [7:0]    cnt, cnt_n, cnt_inc;
   logic          lock, lock_n;
   logic [3:0]    lock_an, lock_an_n;
   logic          legal, same, blocked, cap;

   // Input sample register plus a one-deep history for the stability compare.
   always_ff @(posedge clk) begin
      if (!rst) begin
         an_q   <= 4'hF;
         sseg_q <= BLANK;
         an_p   <= 4'hF;
         sseg_p <= BLANK;
      end else begin
         an_q   <= an;
         sseg_q <= sseg;
         an_p   <= an_q;
         sseg_p <= sseg_q;
      end
   end

   // Settle FSM state, counter and the "already captured this anode" lock.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= ST_SCAN;
         cnt     <= 8'd0;
         lock    <= 1'b0;
         lock_an <= 4'hF;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         lock    <= lock_n;
         lock_an <= lock_an_n;
      end
   end

   assign legal   = an_legal(an_q);
   assign same    = (an_q == an_p) && (sseg_q == sseg_p);
   assign blocked = lock && (an_q == lock_an);
   assign cnt_inc = cnt + 8'd1;

   // Next-state logic: count stable samples, capture at SETTLE, then lock
   // out the same anode until it changes so a digit is captured once per visit.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      cap       = 1'b0;
      lock_n    = lock && (an_q == lock_an);
      lock_an_n = lock_an;
      case (state)
         ST_SCAN: begin
            if (legal && !blocked) begin
               cnt_n   = 8'd1;
               state_n = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (same) begin
               cnt_n = cnt_inc;
               if (cnt_inc == SETTLE_C) begin
                  cap       = 1'b1;
                  state_n   = ST_SCAN;
                  lock_n    = 1'b1;
                  lock_an_n = an_q;
               end
            end else if (legal) begin
               cnt_n = 8'd1;
            end else begin
               cnt_n   = 8'd0;
               state_n = ST_SCAN;
            end
         end
         default: state_n = ST_SCAN;
      endcase
   end

   assign cap_valid   = cap;
   assign cap_idx     = an_index(an_q);
   assign cap_pattern = sseg_q;
   assign state_dbg   = state;

endmodule

// File: rtl/sseg_scan_decoder.sv
// Rebuilds the 4-digit frame from captured digits, classifies it as a
// rotating-square position and reports +/-1 steps and illegal frames/jumps.
module sseg_scan_decoder
   import sseg_pkg::*;
#(
   parameter int unsigned SETTLE = 4,
   parameter int unsigned DIGITS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  an,
   input  logic [6:0]  sseg,
   output logic        frame_valid,
   output logic [27:0] frame,
   output logic        pos_valid,
   output logic [2:0]  pos,
   output logic        step,
   output logic        dir_up,
   output logic        err
);

   logic          cap_valid;
   logic [1:0]    cap_idx;
   logic [6:0]    cap_pattern;
   settle_state_t dbg_state_unused;  // exposed for checker binding only

   logic [3:0]    mask, mask_n;
   logic          have_prev;
   logic [2:0]    nonblank;
   logic          hit_legal, cls_legal;
   logic [2:0]    cls_pos, diff;
   logic [3:0]    dec;
   logic [6:0]    slot;

   sseg_digit_capture #(.SETTLE(SETTLE)) u_capture (
      .clk         (clk),
      .rst         (rst),
      .an          (an),
      .sseg        (sseg),
      .cap_valid   (cap_valid),
      .cap_idx     (cap_idx),
      .cap_pattern (cap_pattern),
      .state_dbg   (dbg_state_unused)
   );

   // Mask clears on completion; a capture in the same cycle lands after the clear.
   always_comb begin
      mask_n = (mask == 4'hF) ? 4'h0 : mask;
      if (cap_valid)
         mask_n[cap_idx] = 1'b1;
   end

   // Classify the stored frame: exactly one non-blank digit that is a square.
   always_comb begin
      nonblank  = 3'd0;
      hit_legal = 1'b0;
      cls_pos   = 3'd0;
      dec       = 4'h0;
      slot      = BLANK;
      for (int d = 0; d < DIGITS; d++) begin
         slot = frame[7*d +: 7];
         if (slot != BLANK) begin
            nonblank  = nonblank + 3'd1;
            dec       = pattern_to_pos(2'(d), slot);
            hit_legal = dec[3];
            cls_pos   = dec[2:0];
         end
      end
      cls_legal = (nonblank == 3'd1) && hit_legal;
      diff      = cls_pos - pos;
   end

   // Frame storage, completion pulse and position/step/error status.
   always_ff @(posedge clk) begin
      if (!rst) begin
         frame       <= 28'hFFFFFFF;
         mask        <= 4'h0;
         frame_valid <= 1'b0;
         pos_valid   <= 1'b0;
         pos         <= 3'd0;
         step        <= 1'b0;
         dir_up      <= 1'b0;
         err         <= 1'b0;
         have_prev   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         step        <= 1'b0;
         mask        <= mask_n;
         if (cap_valid)
            frame[7*cap_idx +: 7] <= cap_pattern;
         if (mask == 4'hF) begin
            frame_valid <= 1'b1;
            if (cls_legal) begin
               pos       <= cls_pos;
               pos_valid <= 1'b1;
               have_prev <= 1'b1;
               if (have_prev) begin
                  if (diff == 3'd1) begin
                     step   <= 1'b1;
                     dir_up <= 1'b1;
                  end else if (diff == 3'd7) begin
                     step   <= 1'b1;
                     dir_up <= 1'b0;
                  end else if (diff != 3'd0) begin
                     err <= 1'b1;
                  end
               end
            end else begin
               pos_valid <= 1'b0;
               err       <= 1'b1;
               have_prev <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: drives scanned digit sequences, predicts each
// completed frame's status in a reference model and checks it on frame_valid.
module tb_sseg_scan_decoder;

   localparam int W = 35;  // {frame, pos_valid, pos, step, dir_up, err}
   localparam logic [6:0] P_UP  = 7'h1C;
   localparam logic [6:0] P_LO  = 7'h23;
   localparam logic [6:0] P_BL  = 7'h7F;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  an = 4'hF;
   logic [6:0]  sseg = 7'h7F;
   logic        frame_valid, pos_valid, step, dir_up, err;
   logic [27:0] frame;
   logic [2:0]  pos;

   int vectors = 0;
   int miscompares = 0;
   int frames_seen = 0;
   logic [W-1:0] exp_q[$];

   // reference model state
   logic [2:0] m_pos;
   logic       m_dir, m_err, m_prev_valid;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   sseg_scan_decoder #(.SETTLE(4), .DIGITS(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .an          (an),
      .sseg        (sseg),
      .frame_valid (frame_valid),
      .frame       (frame),
      .pos_valid   (pos_valid),
      .pos         (pos),
      .step        (step),
      .dir_up      (dir_up),
      .err         (err)
   );

   task automatic model_reset();
      m_pos = 3'd0;
      m_dir = 1'b0;
      m_err = 1'b0;
      m_prev_valid = 1'b0;
      exp_q.delete();
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      an = 4'hF;
      sseg = P_BL;
      repeat (3) @(negedge clk);
      model_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // ---------------- driver tasks ----------------
   function automatic logic [27:0] frame_of(input logic [2:0] p);
      logic [27:0] f;
      int d;
      f = 28'hFFFFFFF;
      if (p < 3'd4) begin
         d = int'(p);
         f[7*d +: 7] = P_UP;
      end else begin
         d = 7 - int'(p);
         f[7*d +: 7] = P_LO;
      end
      return f;
   endfunction

   task automatic show(input int d, input logic [6:0] p, input int n);
      an = ~(4'b0001 << d);
      sseg = p;
      repeat (n) @(negedge clk);
   endtask

   task automatic idle(input int n);
      an = 4'hF;
      sseg = P_BL;
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [27:0] f, input int hold);
      for (int d = 0; d < 4; d++)
         show(d, f[7*d +: 7], hold);
   endtask

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic expect_legal(input logic [2:0] p, input logic [27:0] f);
      logic [2:0] d;
      logic       s;
      s = 1'b0;
      if (m_prev_valid) begin
         d = p - m_pos;
         if (d == 3'd1) begin
            s = 1'b1; m_dir = 1'b1;
         end else if (d == 3'd7) begin
            s = 1'b1; m_dir = 1'b0;
         end else if (d != 3'd0) begin
            m_err = 1'b1;
         end
      end
      m_pos = p;
      m_prev_valid = 1'b1;
      exp_q.push_back({f, 1'b1, p, s, m_dir, m_err});
   endtask

   task automatic expect_illegal(input logic [27:0] f);
      m_err = 1'b1;
      m_prev_valid = 1'b0;
      exp_q.push_back({f, 1'b0, m_pos, 1'b0, m_dir, 1'b1});
   endtask

   always @(negedge clk) begin
      logic [W-1:0] got, exp;
      if (rst && frame_valid) begin
         frames_seen++;
         got = {frame, pos_valid, pos, step, dir_up, err};
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_frame: got %h, required no frame", got);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               miscompares++;
               $display("FAIL frame_status: got %h, required %h", got, exp);
            end
         end
      end
      if (rst && step && !frame_valid) begin
         miscompares++;
         $display("FAIL step_alone: step=1 without frame_valid, required 0");
      end
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      an = 4'b1110;
      sseg = P_UP;
      repeat (2) @(negedge clk);
      vectors++;
      if ({frame_valid, pos_valid, pos, step, dir_up, err} !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b, required 00000000",
                  {frame_valid, pos_valid, pos, step, dir_up, err});
      end
      vectors++;
      if (frame !== 28'hFFFFFFF) begin
         miscompares++;
         $display("FAIL reset_frame: got %h, required fffffff", frame);
      end
      repeat (8) @(negedge clk);
      vectors++;
      if (frame !== 28'hFFFFFFF) begin
         miscompares++;
         $display("FAIL reset_no_capture: got %h, required fffffff", frame);
      end
      an = 4'hF;
      sseg = P_BL;
      model_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_frame();
      bit ok;
      expect_legal(3'd0, frame_of(3'd0));
      send(frame_of(3'd0), 10);
      wait_drain(ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL frame_timeout: %0d frames pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_clockwise();
      bit ok;
      for (int i = 1; i <= 8; i++) begin
         expect_legal(3'(i), frame_of(3'(i)));
         send(frame_of(3'(i)), 10);
      end
      wait_drain(ok);
      vectors++;
      if (!ok || err !== 1'b0) begin
         miscompares++;
         $display("FAIL cw_end: drained=%0d err=%b, required drained=1 err=0", ok, err);
      end
   endtask

   task automatic test_counter_clockwise();
      bit ok;
      logic [2:0] seq [7] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd7, 3'd0};
      apply_reset();
      foreach (seq[i]) begin
         expect_legal(seq[i], frame_of(seq[i]));
         send(frame_of(seq[i]), 10);
      end
      wait_drain(ok);
      vectors++;
      if (!ok || dir_up !== 1'b1 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL ccw_end: drained=%0d dir_up=%b err=%b, required 1 1 0", ok, dir_up, err);
      end
   endtask

   task automatic test_settle_glitch();
      bit ok;
      int seen;
      apply_reset();
      seen = frames_seen;
      show(0, P_UP, 10);
      show(1, P_BL, 3);       // one cycle short of SETTLE
      show(2, P_BL, 10);
      show(3, P_BL, 10);
      an = 4'b1100;           // two anodes low: ignored
      sseg = P_UP;
      repeat (10) @(negedge clk);
      idle(20);
      vectors++;
      if (frames_seen != seen || err !== 1'b0 || pos_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch_ignored: frames=%0d err=%b pos_valid=%b, required frames=%0d err=0 pos_valid=0",
                  frames_seen, err, pos_valid, seen);
      end
      expect_legal(3'd0, frame_of(3'd0));
      show(1, P_BL, 4);       // exactly SETTLE completes the frame
      idle(10);
      wait_drain(ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL settle_exact: %0d frames pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_illegal();
      bit ok;
      logic [27:0] f;
      apply_reset();
      expect_legal(3'd2, frame_of(3'd2));
      send(frame_of(3'd2), 10);
      f = 28'hFFFFFFF;
      f[6:0] = P_UP;
      f[13:7] = P_UP;
      expect_illegal(f);
      send(f, 10);
      f = 28'hFFFFFFF;
      f[20:14] = 7'h00;
      expect_illegal(f);
      send(f, 10);
      expect_legal(3'd3, frame_of(3'd3));
      send(frame_of(3'd3), 10);
      wait_drain(ok);
      vectors++;
      if (!ok || err !== 1'b1 || pos !== 3'd3) begin
         miscompares++;
         $display("FAIL illegal_frame: drained=%0d err=%b pos=%0d, required 1 1 3", ok, err, pos);
      end
      apply_reset();
      expect_legal(3'd1, frame_of(3'd1));
      send(frame_of(3'd1), 10);
      expect_legal(3'd4, frame_of(3'd4));
      send(frame_of(3'd4), 10);
      expect_legal(3'd5, frame_of(3'd5));
      send(frame_of(3'd5), 10);
      wait_drain(ok);
      vectors++;
      if (!ok || err !== 1'b1 || pos !== 3'd5) begin
         miscompares++;
         $display("FAIL illegal_jump: drained=%0d err=%b pos=%0d, required 1 1 5", ok, err, pos);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [2:0] p;
      apply_reset();
      p = 3'($urandom_range(0, 7));
      for (int i = 0; i < 14; i++) begin
         expect_legal(p, frame_of(p));
         send(frame_of(p), $urandom_range(5, 12));
         p = p + 3'($urandom_range(0, 2)) - 3'd1;
      end
      wait_drain(ok);
      vectors++;
      if (!ok || err !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_end: drained=%0d err=%b, required 1 0", ok, err);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_frame();
      test_clockwise();
      test_counter_clockwise();
      test_settle_glitch();
      test_illegal();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
